// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: parallel-load, LSB-first serializer with handshake, stall and done pulse
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] shreg;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    shreg   <= in_data;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: if (shift_en) begin
                    shreg   <= {1'b0, shreg[WIDTH-1:1]};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(WIDTH-1)) state <= DONE;
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end
    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign ser_valid = (state == SHIFT) & shift_en;
    assign done      = (state == DONE);
    assign ser_out   = shreg[0];
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed scenario tasks for the serializer with hand-computed streams
module tb_shift_seq_ctrl;
    logic clk, reset, in_valid, in_ready, shift_en, ser_out, ser_valid, busy, done;
    logic [7:0] in_data;
    logic [5:0] bit_cnt;
    int n_checks = 0;
    int n_fails = 0;

    shift_seq_ctrl #(.WIDTH(8), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .shift_en(shift_en), .ser_out(ser_out),
        .ser_valid(ser_valid), .busy(busy), .done(done), .bit_cnt(bit_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 1; in_data = 8'h55; shift_en = 1;
        step(); step();
        reset = 0; in_valid = 0; shift_en = 0;
        #1;
        n_checks++;
        if ({in_ready, busy, done, ser_valid, ser_out, bit_cnt} !== {5'b10000, 6'd0}) begin
            n_fails++;
            $display("FAIL reset_state got %b want %b", {in_ready, busy, done, ser_valid, ser_out, bit_cnt}, {5'b10000, 6'd0});
        end
    endtask

    task automatic test_basic();
        bit s[8] = '{1,0,1,0,0,1,0,1};
        in_valid = 1; in_data = 8'hA5; shift_en = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if ({busy, ser_valid, ser_out, done, bit_cnt} !== {1'b1, 1'b1, s[i], 1'b0, 6'(i)}) begin
                n_fails++;
                $display("FAIL basic_bit%0d got %b want %b", i, {busy, ser_valid, ser_out, done, bit_cnt}, {1'b1, 1'b1, s[i], 1'b0, 6'(i)});
            end
            step();
        end
        #1;
        n_checks++;
        if ({busy, done, in_ready, bit_cnt} !== {3'b010, 6'd8}) begin
            n_fails++;
            $display("FAIL basic_done got %b want %b", {busy, done, in_ready, bit_cnt}, {3'b010, 6'd8});
        end
        step(); #1;
        n_checks++;
        if ({busy, done, in_ready, bit_cnt} !== {3'b001, 6'd0}) begin
            n_fails++;
            $display("FAIL basic_after got %b want %b", {busy, done, in_ready, bit_cnt}, {3'b001, 6'd0});
        end
        shift_en = 0;
    endtask

    task automatic test_stall();
        bit s[8] = '{0,0,1,1,1,1,0,0};
        in_valid = 1; in_data = 8'h3C; shift_en = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2 || i == 5) begin
                shift_en = 0;
                repeat (3) begin
                    #1;
                    n_checks++;
                    if ({busy, ser_valid, ser_out, done, bit_cnt} !== {1'b1, 1'b0, s[i], 1'b0, 6'(i)}) begin
                        n_fails++;
                        $display("FAIL stall_hold%0d got %b want %b", i, {busy, ser_valid, ser_out, done, bit_cnt}, {1'b1, 1'b0, s[i], 1'b0, 6'(i)});
                    end
                    step();
                end
                shift_en = 1;
            end
            #1;
            n_checks++;
            if ({busy, ser_valid, ser_out, done, bit_cnt} !== {1'b1, 1'b1, s[i], 1'b0, 6'(i)}) begin
                n_fails++;
                $display("FAIL stall_bit%0d got %b want %b", i, {busy, ser_valid, ser_out, done, bit_cnt}, {1'b1, 1'b1, s[i], 1'b0, 6'(i)});
            end
            step();
        end
        #1;
        n_checks++;
        if ({busy, done, in_ready, bit_cnt} !== {3'b010, 6'd8}) begin
            n_fails++;
            $display("FAIL stall_done got %b want %b", {busy, done, in_ready, bit_cnt}, {3'b010, 6'd8});
        end
        step();
        shift_en = 0;
    endtask

    task automatic test_back_to_back();
        bit s[8] = '{1,0,0,0,0,0,0,0};
        in_valid = 1; in_data = 8'hFF; shift_en = 1;
        step();
        in_data = 8'h01;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if ({in_ready, busy, ser_out, bit_cnt} !== {3'b011, 6'(i)}) begin
                n_fails++;
                $display("FAIL b2b_first%0d got %b want %b", i, {in_ready, busy, ser_out, bit_cnt}, {3'b011, 6'(i)});
            end
            step();
        end
        #1;
        n_checks++;
        if ({in_ready, done} !== 2'b01) begin
            n_fails++;
            $display("FAIL b2b_done got %b want 01", {in_ready, done});
        end
        step(); #1;
        n_checks++;
        if ({in_ready, busy, done} !== 3'b100) begin
            n_fails++;
            $display("FAIL b2b_idle got %b want 100", {in_ready, busy, done});
        end
        step();
        in_valid = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if ({in_ready, busy, ser_valid, ser_out, bit_cnt} !== {1'b0, 1'b1, 1'b1, s[i], 6'(i)}) begin
                n_fails++;
                $display("FAIL b2b_second%0d got %b want %b", i, {in_ready, busy, ser_valid, ser_out, bit_cnt}, {1'b0, 1'b1, 1'b1, s[i], 6'(i)});
            end
            step();
        end
        #1;
        n_checks++;
        if (done !== 1'b1) begin
            n_fails++;
            $display("FAIL b2b_done2 got %b want 1", done);
        end
        step();
        shift_en = 0;
    endtask

    task automatic test_reset_mid();
        bit s[8] = '{1,0,0,0,0,0,0,1};
        in_valid = 1; in_data = 8'hF0; shift_en = 1;
        step();
        in_valid = 0;
        repeat (4) step();
        #1;
        n_checks++;
        if ({busy, bit_cnt, ser_out} !== {1'b1, 6'd4, 1'b1}) begin
            n_fails++;
            $display("FAIL mid_pre got %b want %b", {busy, bit_cnt, ser_out}, {1'b1, 6'd4, 1'b1});
        end
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({in_ready, busy, done, bit_cnt} !== {3'b100, 6'd0}) begin
                n_fails++;
                $display("FAIL mid_after%0d got %b want %b", i, {in_ready, busy, done, bit_cnt}, {3'b100, 6'd0});
            end
            step();
        end
        in_valid = 1; in_data = 8'h81;
        step();
        in_valid = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if ({ser_valid, ser_out, bit_cnt} !== {1'b1, s[i], 6'(i)}) begin
                n_fails++;
                $display("FAIL mid_word%0d got %b want %b", i, {ser_valid, ser_out, bit_cnt}, {1'b1, s[i], 6'(i)});
            end
            step();
        end
        #1;
        n_checks++;
        if ({done, bit_cnt} !== {1'b1, 6'd8}) begin
            n_fails++;
            $display("FAIL mid_done got %b want %b", {done, bit_cnt}, {1'b1, 6'd8});
        end
        step();
        shift_en = 0;
    endtask

    task automatic test_ignored();
        bit s[8] = '{0,1,1,0,1,0,0,1};
        in_valid = 1; in_data = 8'h96; shift_en = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'($urandom);
            #1;
            n_checks++;
            if ({ser_valid, ser_out, bit_cnt} !== {1'b1, s[i], 6'(i)}) begin
                n_fails++;
                $display("FAIL ign_bit%0d got %b want %b", i, {ser_valid, ser_out, bit_cnt}, {1'b1, s[i], 6'(i)});
            end
            step();
        end
        in_valid = 1; in_data = 8'hFF;
        #1;
        n_checks++;
        if ({done, in_ready} !== 2'b10) begin
            n_fails++;
            $display("FAIL ign_done got %b want 10", {done, in_ready});
        end
        step();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({in_ready, busy, done, ser_valid, bit_cnt} !== {4'b1000, 6'd0}) begin
                n_fails++;
                $display("FAIL ign_idle%0d got %b want %b", i, {in_ready, busy, done, ser_valid, bit_cnt}, {4'b1000, 6'd0});
            end
            step();
        end
        shift_en = 0;
    endtask

    initial begin
        reset = 1; in_valid = 0; in_data = '0; shift_en = 0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for a WIDTH-bit chain of D flip-flops used as a parallel-in/serial-out shift register. It accepts a parallel word through a valid/ready handshake, then shifts the word out LSB-first, one bit per enabled cycle. It counts the bits, supports stalls, and pulses done at the end of each word. It sits between a word producer, such as a register file or test stimulus, and any serial consumer in the lab datapath.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
CNT_W, 6, bit_cnt width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock; sole clock of the block
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block can accept a word; high only in IDLE
in_data  input  WIDTH  parallel word; sampled on the accept edge only
shift_en  input  1  advance one bit this cycle; 0 = stall
ser_out  output  1  current serial bit, equal to shreg[0]
ser_valid  output  1  ser_out is consumed this cycle
busy  output  1  high in SHIFT
done  output  1  one-cycle pulse after the last bit
bit_cnt  output  CNT_W  number of bits already shifted out in the current word

Behaviour:
- Registers: state (IDLE / SHIFT / DONE), shreg[WIDTH-1:0], bit_cnt. All updates occur on the rising edge of clk.
- Reset:
  - reset=1 at an edge forces state=IDLE, shreg=0, bit_cnt=0, from any state.
  - An in-flight word is discarded; done does not pulse.
  - After the reset edge: in_ready=1; ser_out, ser_valid, busy, done, bit_cnt all 0.
  - While reset=1, in_valid and shift_en are ignored.
- Decoded outputs (combinational from registers):
  - in_ready = (state==IDLE)
  - busy = (state==SHIFT)
  - ser_valid = (state==SHIFT) & shift_en
  - done = (state==DONE)
  - ser_out = shreg[0]
- IDLE:
  - Accept occurs when in_valid & in_ready at an edge: shreg<=in_data, bit_cnt<=0, state<=SHIFT.
  - Otherwise hold; shreg keeps its old value, so ser_out is don't-care-stable.
- SHIFT:
  - shift_en=1: shreg<=shreg>>1 with 0 filled at the MSB; bit_cnt<=bit_cnt+1.
  - If bit_cnt==WIDTH-1 at that edge, state<=DONE; bit_cnt becomes WIDTH.
  - shift_en=0: all registers hold; ser_valid=0.
- DONE:
  - Lasts exactly one cycle with done=1, then state<=IDLE and bit_cnt<=0.
  - in_ready=0 during DONE; in_valid is ignored.
- Latency with no stalls:
  - Accept edge at cycle N. Bit i is on ser_out with ser_valid=1 in cycle N+1+i, for i=0..WIDTH-1.
  - done=1 in cycle N+WIDTH+1; in_ready=1 again in cycle N+WIDTH+2.
  - Each stalled cycle adds one cycle to the remaining schedule.
- in_data changes after the accept edge have no effect on the word being shifted.
- bit_cnt never exceeds WIDTH and never wraps.
- shift_en high in IDLE or DONE has no effect.
- in_valid held high continuously: a new word is accepted on the first IDLE edge, giving a back-to-back period of WIDTH+2 cycles.

Test Plan:
- Reset then idle: assert reset for 2 cycles, then release -> in_ready=1, busy=0, done=0, ser_valid=0, bit_cnt=0.
- Basic word, WIDTH=8: in_data=8'hA5, shift_en=1 throughout -> ser_out over the 8 valid cycles = 1,0,1,0,0,1,0,1. done pulses exactly once, 9 cycles after the accept edge. bit_cnt reads 8 during done, then 0.
- Stall: in_data=8'h3C, shift_en=0 on bits 2 and 5 for 3 cycles each -> ser_valid is low during stalls. ser_out and bit_cnt hold their values. The valid bit sequence is 0,0,1,1,1,1,0,0. done arrives 6 cycles later than the unstalled case.
- Handshake: in_valid held high with in_data=8'hFF, then 8'h01 -> the second word is accepted only in the cycle after done. in_ready stays 0 during SHIFT and DONE. The second word's serial stream is 1,0,0,0,0,0,0,0.
- Reset mid-word: assert reset after 4 bits of 8'hF0 -> next cycle state IDLE, bit_cnt=0, in_ready=1, and no done pulse. A following word 8'h81 then shifts 1,0,0,0,0,0,0,1 correctly.
- Ignored inputs: change in_data during SHIFT, and pulse in_valid during DONE -> the output stream is unaffected, and no extra word is accepted.
